// File: rtl/dcache_wb_if.sv
// Bus bundle for the write-back data cache: word-addressed pipeline port plus
// 128-bit block port toward data memory.
interface dcache_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  // Environment side: pipeline MEM stage and the data memory.
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Cache side.
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache. Hits never stall; misses
// run an optional dirty writeback followed by a line fill.
module dcache_wb #(
  parameter int NUM_BLOCKS = 8
) (
  input logic         clk,
  input logic         rst_n,
  dcache_wb_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t                 state;
  logic [NUM_BLOCKS-1:0]  valid;
  logic [NUM_BLOCKS-1:0]  dirty;
  logic [TAG_W-1:0]       tag_mem  [NUM_BLOCKS];
  logic [127:0]           data_mem [NUM_BLOCKS];

  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [27:0]            mem_addr_q;
  logic [127:0]           mem_wdata_q;

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [6:0]             word_lsb;
  logic [127:0]           line;
  logic                   req;
  logic                   hit;
  logic                   rd_hit;
  logic                   wr_hit;

  assign idx      = bus.proc_addr[IDX_W+1:2];
  assign tag      = bus.proc_addr[29:IDX_W+2];
  assign word_lsb = {bus.proc_addr[1:0], 5'b00000};
  assign line     = data_mem[idx];
  assign req      = bus.proc_read | bus.proc_write;
  assign hit      = req & valid[idx] & (tag_mem[idx] == tag);

  // A simultaneous read and write request is served as a write.
  assign rd_hit   = (state == IDLE) & hit & bus.proc_read & ~bus.proc_write;
  assign wr_hit   = (state == IDLE) & hit & bus.proc_write;

  assign bus.proc_stall = (state != IDLE) | (req & ~hit);
  assign bus.proc_rdata = rd_hit ? line[word_lsb +: 32] : 32'h0;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // Control FSM; memory-side outputs are registered so they never depend on mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state       <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_mem[idx], idx};
              mem_wdata_q <= line;
            end else begin
              state       <= ALLOCATE;
              mem_read_q  <= 1'b1;
              mem_addr_q  <= bus.proc_addr[29:2];
            end
          end else if (wr_hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            state       <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= bus.proc_addr[29:2];
            mem_wdata_q <= '0;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            valid[idx]  <= 1'b1;
            dirty[idx]  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && bus.mem_ready) begin
      data_mem[idx] <= bus.mem_rdata;
      tag_mem[idx]  <= tag;
    end else if (wr_hit) begin
      data_mem[idx][word_lsb +: 32] <= bus.proc_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Randomized self-checking bench for dcache_wb: a behavioural cache/memory model
// predicts stall lengths, load data, writebacks and fills.
module tb_dcache_wb;
  localparam int NB = 8;
  localparam int TW = 25;

  logic clk;
  logic rst_n;
  dcache_wb_if bus ();

  dcache_wb #(.NUM_BLOCKS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents seen by the responder, and the model's own image.
  logic [127:0] mem_img [logic [27:0]];
  logic [127:0] ref_img [logic [27:0]];
  logic [31:0]  salt;

  // Model cache state.
  bit           m_valid [NB];
  bit           m_dirty [NB];
  logic [TW-1:0] m_tag  [NB];
  logic [127:0] m_data  [NB];

  // Responder bookkeeping.
  int           mem_lat = 4;
  int           wb_cnt, fill_cnt, both_cnt, unstable_cnt;
  logic [27:0]  wb_addr, fill_addr;
  logic [127:0] wb_data;

  function automatic logic [127:0] init_block(input logic [27:0] a);
    logic [31:0] w;
    w = 32'(a);
    return {w * 32'h9E3779B1 ^ salt, w * 32'h85EBCA6B + salt,
            ~w ^ (salt << 3), w + 32'h1234_0000 ^ salt};
  endfunction

  function automatic logic [127:0] mem_fetch(input logic [27:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return init_block(a);
  endfunction

  function automatic logic [127:0] ref_fetch(input logic [27:0] a);
    if (ref_img.exists(a)) return ref_img[a];
    return init_block(a);
  endfunction

  // Data memory: level-held request, one-cycle mem_ready after mem_lat cycles.
  initial begin
    int          cnt;
    logic [27:0] req_addr;
    logic [127:0] req_wdata;
    logic        req_wr;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        cnt = 0;
      end else begin
        if (bus.mem_ready) begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = '0;
          cnt = 0;
        end
        if (bus.mem_read && bus.mem_write) both_cnt++;
        if (bus.mem_read || bus.mem_write) begin
          cnt++;
          if (cnt == 1) begin
            req_addr  = bus.mem_addr;
            req_wdata = bus.mem_wdata;
            req_wr    = bus.mem_write;
          end else if (bus.mem_addr !== req_addr || bus.mem_write !== req_wr ||
                       (req_wr && bus.mem_wdata !== req_wdata)) begin
            unstable_cnt++;
          end
          if (cnt >= mem_lat) begin
            if (bus.mem_write) begin
              mem_img[bus.mem_addr] = bus.mem_wdata;
              wb_cnt++;
              wb_addr = bus.mem_addr;
              wb_data = bus.mem_wdata;
            end else begin
              bus.mem_rdata = mem_fetch(bus.mem_addr);
              fill_cnt++;
              fill_addr = bus.mem_addr;
            end
            bus.mem_ready = 1'b1;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic idle_cycle();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    @(negedge clk);
  endtask

  // One processor access, started on a negedge; returns on the negedge after it commits.
  task automatic access(input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                        input int lat, input string name);
    logic [2:0]    idx;
    logic [TW-1:0] tg;
    int            off;
    bit            mhit, mwb;
    int            exp_stall, stalled;
    logic [127:0]  old_line;
    logic [31:0]   exp_word;
    idx       = addr[4:2];
    tg        = addr[29:5];
    off       = int'(addr[1:0]);
    mhit      = m_valid[idx] && (m_tag[idx] == tg);
    mwb       = !mhit && m_valid[idx] && m_dirty[idx];
    exp_stall = mhit ? 0 : (mwb ? 2 * lat + 1 : lat + 1);
    old_line  = m_data[idx];

    mem_lat  = lat;
    wb_cnt   = 0;
    fill_cnt = 0;
    bus.proc_read  = !wr;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wd;
    #1;
    stalled = 0;
    while (bus.proc_stall === 1'b1 && stalled < 200) begin
      stalled++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (stalled !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, stalled, exp_stall);
    end
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL %s mem_idle got rd=%b wr=%b want 0 0", name, bus.mem_read, bus.mem_write);
    end

    if (!mhit) begin
      checks++;
      if (wb_cnt !== (mwb ? 1 : 0) || fill_cnt !== 1 || fill_addr !== addr[29:2]) begin
        errors++;
        $display("FAIL %s traffic got wb=%0d fill=%0d fill_addr=%h want wb=%0d fill=1 fill_addr=%h",
                 name, wb_cnt, fill_cnt, fill_addr, mwb ? 1 : 0, addr[29:2]);
      end
      if (mwb) begin
        checks++;
        if (wb_addr !== {m_tag[idx], idx} || wb_data !== old_line) begin
          errors++;
          $display("FAIL %s writeback got %h:%h want %h:%h", name, wb_addr, wb_data,
                   {m_tag[idx], idx}, old_line);
        end
        ref_img[{m_tag[idx], idx}] = old_line;
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = ref_fetch(addr[29:2]);
    end

    if (!wr) begin
      exp_word = m_data[idx][32*off +: 32];
      checks++;
      if (bus.proc_rdata !== exp_word) begin
        errors++;
        $display("FAIL %s rdata got %h want %h", name, bus.proc_rdata, exp_word);
      end
    end else begin
      m_data[idx][32*off +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b rd=%b wr=%b want 0 0 0",
               bus.proc_stall, bus.mem_read, bus.mem_write);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_stall got %b want 0", bus.proc_stall);
    end
  endtask

  task automatic test_clean_fill();
    access(1'b0, 30'h4, 32'h0, 4, "fill_read_0x4");
    checks++;
    if (fill_addr !== 28'h1) begin
      errors++;
      $display("FAIL fill_addr got %h want 0000001", fill_addr);
    end
    access(1'b0, 30'h5, 32'h0, 4, "hit_read_0x5");
  endtask

  task automatic test_write_hit();
    access(1'b1, 30'h6, 32'hDEADBEEF, 4, "write_hit_0x6");
    access(1'b0, 30'h6, 32'h0, 4, "read_back_0x6");
    checks++;
    if (m_data[1][95:64] !== 32'hDEADBEEF || wb_cnt !== 0 || fill_cnt !== 0) begin
      errors++;
      $display("FAIL write_hit_state got word=%h wb=%0d fill=%0d want deadbeef 0 0",
               m_data[1][95:64], wb_cnt, fill_cnt);
    end
  endtask

  task automatic test_dirty_evict();
    access(1'b0, 30'h26, 32'h0, 3, "evict_read_0x26");
    checks++;
    if (wb_addr !== 28'h1 || wb_data[95:64] !== 32'hDEADBEEF || fill_addr !== 28'h9) begin
      errors++;
      $display("FAIL evict_addrs got wb=%h w2=%h fill=%h want 0000001 deadbeef 0000009",
               wb_addr, wb_data[95:64], fill_addr);
    end
  endtask

  task automatic test_store_miss();
    access(1'b1, 30'h3C, 32'h12345678, 3, "store_miss_0x3c");
    access(1'b0, 30'h3C, 32'h0, 3, "read_after_store_miss");
    access(1'b0, 30'h7C, 32'h0, 2, "evict_store_line");
    checks++;
    if (wb_addr !== 28'hF || wb_data[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL store_miss_wb got %h/%h want 000000f/12345678", wb_addr, wb_data[31:0]);
    end
  endtask

  task automatic test_reset_mid_alloc();
    int waited;
    logic [2:0] idx;
    idx = 3'(30'h100 >> 2);
    if (m_valid[idx] && m_dirty[idx]) ref_img[{m_tag[idx], idx}] = m_data[idx];
    mem_lat = 8;
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b0;
    bus.proc_addr  = 30'h100;
    waited = 0;
    while (bus.mem_read !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL alloc_before_reset got rd=%b stall=%b want 1 1", bus.mem_read, bus.proc_stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write);
    end
    bus.proc_read = 1'b0;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_stall got %b want 0", bus.proc_stall);
    end
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 30'h26, 32'h0, 2, "refill_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [29:0] a;
    logic [31:0] exp_word;
    access(1'b0, 30'h00, 32'h0, 2, "prime_idx0");
    access(1'b0, 30'h1C, 32'h0, 2, "prime_idx7");
    for (int i = 0; i < 16; i++) begin
      a = (i % 2 == 0) ? 30'(i % 4) : 30'h1C | 30'(i % 4);
      bus.proc_read  = 1'b1;
      bus.proc_write = 1'b0;
      bus.proc_addr  = a;
      #1;
      exp_word = m_data[a[4:2]][32*int'(a[1:0]) +: 32];
      checks++;
      if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
          bus.proc_rdata !== exp_word) begin
        errors++;
        $display("FAIL b2b_%0d got stall=%b rd=%b wr=%b data=%h want 0 0 0 %h", i,
                 bus.proc_stall, bus.mem_read, bus.mem_write, bus.proc_rdata, exp_word);
      end
      @(negedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_random();
    logic [29:0] a;
    bit          wr;
    for (int n = 0; n < 150; n++) begin
      a  = 30'(($urandom_range(0, 3) << 5) | ($urandom_range(0, NB - 1) << 2) | $urandom_range(0, 3));
      wr = ($urandom_range(0, 2) == 0);
      access(wr, a, $urandom, $urandom_range(1, 5), "random");
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_protocol();
    checks++;
    if (both_cnt !== 0 || unstable_cnt !== 0) begin
      errors++;
      $display("FAIL mem_protocol got both_high=%0d unstable=%0d want 0 0", both_cnt, unstable_cnt);
    end
  endtask

  initial begin
    salt = $urandom;
    both_cnt = 0;
    unstable_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    @(negedge clk);
    test_reset();
    test_clean_fill();
    test_write_hit();
    test_dirty_evict();
    test_store_miss();
    test_reset_mid_alloc();
    test_back_to_back();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
